// File: rtl/unary_pkg.sv
`default_nettype none
// ============================================================================
// Package     : unary_pkg
// Description : Shared types and helpers for the unary arithmetic blocks
//               (stream encoder, adders, decoders).
//               - enc_mode_e  : ENC_THERMO (ones first) / ENC_SPREAD (even)
//               - enc_state_e : encoder FSM states
//               - count_width : bits needed to hold a count 0..n
// Revision    : 1.0 - initial release
// ============================================================================
package unary_pkg;

    typedef enum logic {
        ENC_THERMO = 1'b0,
        ENC_SPREAD = 1'b1
    } enc_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } enc_state_e;

    // Width of a counter that must represent every value from 0 to n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unary_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : unary_stream_encoder_if
// Description : Control and bit-stream bundle of the unary stream encoder.
//               master : producer/consumer side (drives clear/load/value/enable)
//               slave  : encoder side (drives y/valid/last/busy)
//   clear  : synchronous abort of the current stream
//   load   : capture value and start a stream (honoured only when idle)
//   value  : binary count, COUNT_WIDTH bits
//   enable : consumer pull, one bit per enabled cycle
//   y      : stream bit, valid : y is a stream bit, last : final bit, busy : streaming
// Revision    : 1.0 - initial release
// ============================================================================
interface unary_stream_encoder_if #(
    parameter int COUNT_WIDTH = 6
);
    logic                   clear;
    logic                   load;
    logic [COUNT_WIDTH-1:0] value;
    logic                   enable;
    logic                   y;
    logic                   valid;
    logic                   last;
    logic                   busy;

    modport master (
        output clear, load, value, enable,
        input  y, valid, last, busy
    );

    modport slave (
        input  clear, load, value, enable,
        output y, valid, last, busy
    );
endinterface
`default_nettype wire

// File: rtl/unary_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : unary_stream_encoder
// Description : Binary-to-unary transmitter. Loads a binary count and emits
//               INPUT_WIDTH serial bits, one per enabled cycle, of which
//               min(value, INPUT_WIDTH) are 1. ENC_THERMO sends the ones
//               first; ENC_SPREAD spreads them so any k-bit prefix holds
//               floor(k*value/INPUT_WIDTH) ones.
// Ports       : clk   - clock
//               reset - asynchronous, active-low reset
//               bus   - unary_stream_encoder_if.slave (clear, load, value,
//                       enable in; y, valid, last, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module unary_stream_encoder
    import unary_pkg::*;
#(
    parameter int        INPUT_WIDTH = 32,
    parameter int        COUNT_WIDTH = count_width(INPUT_WIDTH),
    parameter enc_mode_e ENCODING    = ENC_SPREAD
) (
    input  wire logic               clk,
    input  wire logic               reset,
    unary_stream_encoder_if.slave   bus
);

    localparam logic [COUNT_WIDTH-1:0] c_FULL     = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] c_LAST_IDX = COUNT_WIDTH'(INPUT_WIDTH - 1);

    enc_state_e             r_state,   w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_val_q,   w_val_nxt;
    logic [COUNT_WIDTH-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [COUNT_WIDTH-1:0] r_acc,     w_acc_nxt;
    logic                   r_y,       w_y_nxt;
    logic                   r_valid,   w_valid_nxt;
    logic                   r_last,    w_last_nxt;

    logic [COUNT_WIDTH-1:0] w_val_sat;
    logic                   w_enc_bit;
    logic [COUNT_WIDTH-1:0] w_acc_step;

    assign w_val_sat = (bus.value > c_FULL) ? c_FULL : bus.value;

    // Bit generator: next stream bit and the accumulator value after it.
    generate
        if (ENCODING == ENC_THERMO) begin : g_thermo
            assign w_enc_bit  = (r_bit_cnt < r_val_q);
            assign w_acc_step = r_acc;
        end else begin : g_spread
            localparam logic [COUNT_WIDTH:0] c_FULL_EXT = (COUNT_WIDTH+1)'(INPUT_WIDTH);
            // acc < INPUT_WIDTH and val_q <= INPUT_WIDTH, so one extra bit
            // holds the sum without overflow.
            logic [COUNT_WIDTH:0] w_sum;
            logic [COUNT_WIDTH:0] w_sum_wrap;
            assign w_sum      = {1'b0, r_acc} + {1'b0, r_val_q};
            assign w_sum_wrap = w_sum - c_FULL_EXT;
            always_comb begin
                w_enc_bit  = 1'b0;
                w_acc_step = w_sum[COUNT_WIDTH-1:0];
                if (w_sum >= c_FULL_EXT) begin
                    w_enc_bit  = 1'b1;
                    w_acc_step = w_sum_wrap[COUNT_WIDTH-1:0];
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_val_nxt     = r_val_q;
        w_bit_cnt_nxt = r_bit_cnt;
        w_acc_nxt     = r_acc;
        w_y_nxt       = 1'b0;
        w_valid_nxt   = 1'b0;
        w_last_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.load) begin
                    w_state_nxt   = ST_STREAM;
                    w_val_nxt     = w_val_sat;
                    w_bit_cnt_nxt = '0;
                    w_acc_nxt     = '0;
                end
            end
            ST_STREAM: begin
                if (bus.clear) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.enable) begin
                    w_y_nxt       = w_enc_bit;
                    w_valid_nxt   = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_acc_nxt     = w_acc_step;
                    if (r_bit_cnt == c_LAST_IDX) begin
                        w_last_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                // enable low: stall, bit_cnt and acc hold, outputs idle
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_val_q   <= '0;
            r_bit_cnt <= '0;
            r_acc     <= '0;
            r_y       <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_val_q   <= w_val_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_y       <= w_y_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign bus.y     = r_y;
    assign bus.valid = r_valid;
    assign bus.last  = r_last;
    assign bus.busy  = (r_state == ST_STREAM);

endmodule
`default_nettype wire

// File: tb/tb_unary_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_unary_stream_encoder
// Description : Directed self-checking bench for unary_stream_encoder.
//               One SPREAD and one THERMO instance share clk/reset; sel
//               routes the stimulus and observation to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_stream_encoder;
    import unary_pkg::*;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel;
    logic          load, clear, enable;
    logic [CW-1:0] value;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    unary_stream_encoder_if #(.COUNT_WIDTH(CW)) s_if ();
    unary_stream_encoder_if #(.COUNT_WIDTH(CW)) t_if ();

    assign s_if.load   = load   & ~sel;
    assign s_if.clear  = clear  & ~sel;
    assign s_if.enable = enable & ~sel;
    assign s_if.value  = sel ? '0 : value;
    assign t_if.load   = load   & sel;
    assign t_if.clear  = clear  & sel;
    assign t_if.enable = enable & sel;
    assign t_if.value  = sel ? value : '0;

    unary_stream_encoder #(.INPUT_WIDTH(W), .COUNT_WIDTH(CW), .ENCODING(ENC_SPREAD)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    unary_stream_encoder #(.INPUT_WIDTH(W), .COUNT_WIDTH(CW), .ENCODING(ENC_THERMO)) dut_t (
        .clk   (clk),
        .reset (reset),
        .bus   (t_if)
    );

    logic obs_y, obs_valid, obs_last, obs_busy;
    assign obs_y     = sel ? t_if.y     : s_if.y;
    assign obs_valid = sel ? t_if.valid : s_if.valid;
    assign obs_last  = sel ? t_if.last  : s_if.last;
    assign obs_busy  = sel ? t_if.busy  : s_if.busy;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loads v, then pulls bits until busy drops. toggle=1 drives enable
    // 0,1,0,1,... starting low; otherwise enable stays high.
    task automatic run_stream(input string tag, input logic [CW-1:0] v, input bit toggle,
                              output logic [31:0] bits, output int nval, output int ncyc);
        int  lastpos;
        int  lastcyc;
        bit  done;
        bit  vfe_bad;
        bits    = '0;
        nval    = 0;
        ncyc    = 0;
        lastpos = -1;
        lastcyc = -1;
        done    = 1'b0;
        vfe_bad = 1'b0;
        value   = v;
        load    = 1'b1;
        enable  = 1'b0;
        step();
        load    = 1'b0;
        check({tag, "_start_busy_gap"}, {30'd0, obs_busy, obs_valid}, 32'h2);
        for (int c = 0; c < 200 && !done; c++) begin
            enable = toggle ? c[0] : 1'b1;
            step();
            ncyc++;
            if (obs_valid !== enable) vfe_bad = 1'b1;
            if (obs_valid === 1'b1 && nval < 32) begin
                bits[nval] = obs_y;
                nval++;
                if (obs_last === 1'b1) begin
                    lastpos = nval;
                    lastcyc = ncyc;
                end
            end
            if (obs_busy !== 1'b1) done = 1'b1;
        end
        enable = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_valid_follows_enable"}, {31'd0, vfe_bad}, 32'd0);
        check({tag, "_last_pos"}, lastpos, 32'd32);
        check({tag, "_busy_falls_with_last"}, lastcyc, ncyc);
    endtask

    logic [31:0] bits, bits_ref;
    int          nval, ncyc;
    int          pfx_bad;
    int          ones;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        sel    = 1'b0;
        load   = 1'b0;
        clear  = 1'b0;
        enable = 1'b0;
        value  = '0;
        #12;
        check("reset_outputs_s", {28'd0, s_if.y, s_if.valid, s_if.last, s_if.busy}, 32'd0);
        check("reset_outputs_t", {28'd0, t_if.y, t_if.valid, t_if.last, t_if.busy}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // SPREAD 16: alternating 0,1 starting with 0
        run_stream("s16", 6'd16, 1'b0, bits, nval, ncyc);
        check("s16_bits", bits, 32'hAAAAAAAA);
        check("s16_count", nval, 32'd32);
        check("s16_cycles", ncyc, 32'd32);
        check("s16_ones", $countones(bits), 32'd16);

        // back-to-back: load in the cycle right after last
        run_stream("s0", 6'd0, 1'b0, bits, nval, ncyc);
        check("s0_bits", bits, 32'h00000000);
        check("s0_count", nval, 32'd32);

        run_stream("s32", 6'd32, 1'b0, bits, nval, ncyc);
        check("s32_bits", bits, 32'hFFFFFFFF);

        run_stream("s40", 6'd40, 1'b0, bits, nval, ncyc);
        check("s40_sat_bits", bits, 32'hFFFFFFFF);

        // SPREAD 11: ones at bit numbers 3,6,...,30,32
        run_stream("s11", 6'd11, 1'b0, bits, nval, ncyc);
        check("s11_bits", bits, 32'hA4924924);
        pfx_bad = 0;
        ones    = 0;
        for (int k = 1; k <= 32; k++) begin
            ones += int'(bits[k-1]);
            if (ones != (11 * k) / 32) pfx_bad++;
        end
        check("s11_prefix_floor", pfx_bad, 32'd0);

        // SPREAD 10 unstalled, then stalled every other cycle
        run_stream("s10", 6'd10, 1'b0, bits, nval, ncyc);
        check("s10_bits", bits, 32'h92489248);
        bits_ref = bits;
        run_stream("s10t", 6'd10, 1'b1, bits, nval, ncyc);
        check("s10t_bits_same", bits, bits_ref);
        check("s10t_cycles", ncyc, 32'd64);
        check("s10t_count", nval, 32'd32);

        // THERMO 5: five ones then zeros
        sel = 1'b1;
        step();
        run_stream("t5", 6'd5, 1'b0, bits, nval, ncyc);
        check("t5_bits", bits, 32'h0000001F);
        check("t5_cycles", ncyc, 32'd32);
        sel = 1'b0;
        step();

        // asynchronous reset after 10 bits
        value  = 6'd20;
        load   = 1'b1;
        step();
        load   = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("rst_pre_busy_valid", {30'd0, obs_busy, obs_valid}, 32'h3);
        reset = 1'b0;
        #1;
        check("rst_async_outputs", {29'd0, obs_y, obs_valid, obs_busy}, 32'd0);
        enable = 1'b0;
        step();
        reset = 1'b1;
        step();
        run_stream("s3", 6'd3, 1'b0, bits, nval, ncyc);
        check("s3_ones", $countones(bits), 32'd3);
        check("s3_count", nval, 32'd32);

        // clear after 7 bits, with an ignored load pulsed mid-stream
        value  = 6'd16;
        load   = 1'b1;
        step();
        load   = 1'b0;
        enable = 1'b1;
        bits   = '0;
        nval   = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                load  = 1'b1;
                value = 6'd32;
            end else begin
                load  = 1'b0;
            end
            step();
            if (obs_valid === 1'b1) begin
                bits[nval] = obs_y;
                nval++;
            end
        end
        load = 1'b0;
        check("clr_pre_bits", bits, 32'h0000002A);
        check("clr_pre_busy", {31'd0, obs_busy}, 32'd1);
        clear = 1'b1;
        step();
        clear  = 1'b0;
        enable = 1'b0;
        check("clr_idle", {29'd0, obs_valid, obs_last, obs_busy}, 32'd0);
        step();
        run_stream("s16b", 6'd16, 1'b0, bits, nval, ncyc);
        check("s16b_bits", bits, 32'hAAAAAAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
